idex_hazard_reg: RTL

- ID/EX pipeline stage for the 16-bit, 16-register 5-stage core; sits directly upstream of the forwarding unit and supplies its IDEX_Rs/IDEX_Rt operands.
- Latches decoded ID-stage fields each cycle.
- Detects load-use hazards, inserts a one-cycle bubble and freezes PC and IF/ID.
- Squashes on a taken branch; honours a global memory stall; keeps a saturating stall-cycle counter.

---
 rtl/idex_hazard_reg_pkg.sv | 33 +++
 rtl/idex_hazard_reg_if.sv | 40 ++++
 rtl/idex_hazard_reg_load_use_detect.sv | 23 ++
 rtl/idex_hazard_reg.sv | 101 ++++++++++
 4 files changed

// File: rtl/idex_hazard_reg_pkg.sv
// Shared pipeline definitions: widths, ALU opcodes, ID/EX FSM encoding and the bubble control vector.
package pipe_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  // State records where the current ID/EX contents came from
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    FLUSH  = 2'b10
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(4'b0000);

  typedef enum logic [1:0] {
    LD_HOLD   = 2'd0,
    LD_BUBBLE = 2'd1,
    LD_FIELDS = 2'd2
  } ld_e;
endpackage

// File: rtl/idex_hazard_reg_if.sv
// ID-stage inputs, ID/EX register outputs and hazard-control outputs of the ID/EX stage.
interface idex_hazard_reg_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
);
  logic              mem_stall, ex_branch_taken;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;
  logic              id_uses_rs, id_uses_rt, id_is_store;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [3:0]        id_alu_op;
  logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;

  logic              idex_valid;
  logic [REG_W-1:0]  idex_rs, idex_rt, idex_rd;
  logic [DATA_W-1:0] idex_rs_data, idex_rt_data, idex_imm;
  logic [3:0]        idex_alu_op;
  logic              idex_reg_write, idex_mem_read, idex_mem_write, idex_mem_to_reg;
  logic              pc_write, ifid_write, ifid_flush, load_use;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output mem_stall, ex_branch_taken, id_valid, id_rs, id_rt, id_rd,
           id_uses_rs, id_uses_rt, id_is_store, id_rs_data, id_rt_data, id_imm,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    input  idex_valid, idex_rs, idex_rt, idex_rd, idex_rs_data, idex_rt_data,
           idex_imm, idex_alu_op, idex_reg_write, idex_mem_read, idex_mem_write,
           idex_mem_to_reg, pc_write, ifid_write, ifid_flush, load_use, stall_count
  );

  modport slave (
    input  mem_stall, ex_branch_taken, id_valid, id_rs, id_rt, id_rd,
           id_uses_rs, id_uses_rt, id_is_store, id_rs_data, id_rt_data, id_imm,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
    output idex_valid, idex_rs, idex_rt, idex_rd, idex_rs_data, idex_rt_data,
           idex_imm, idex_alu_op, idex_reg_write, idex_mem_read, idex_mem_write,
           idex_mem_to_reg, pc_write, ifid_write, ifid_flush, load_use, stall_count
  );
endinterface

// File: rtl/idex_hazard_reg_load_use_detect.sv
// Load-use hazard equation: a load in ID/EX whose destination is read by the instruction in ID.
module load_use_detect #(
  parameter int REG_W = 4
) (
  input  logic             idex_valid,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_store,
  output logic             load_use
);
  logic h_rs, h_rt;

  assign h_rs = id_uses_rs && (id_rs == idex_rd);
  // Store data reaches MEM through MEM-to-MEM forwarding, so rt of a store never stalls
  assign h_rt = id_uses_rt && (id_rt == idex_rd) && !id_is_store;

  assign load_use = idex_valid && idex_mem_read && (idex_rd != '0) && id_valid && (h_rs || h_rt);
endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash, memory freeze and stall counter.
module idex_hazard_reg #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  idex_hazard_reg_if.slave bus
);
  import pipe_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e state, state_d;
  ld_e    ld_sel;
  logic   cnt_inc;
  logic   hazard;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .idex_valid   (bus.idex_valid),
    .idex_mem_read(bus.idex_mem_read),
    .idex_rd      (bus.idex_rd),
    .id_valid     (bus.id_valid),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_uses_rs   (bus.id_uses_rs),
    .id_uses_rt   (bus.id_uses_rt),
    .id_is_store  (bus.id_is_store),
    .load_use     (hazard)
  );

  assign bus.load_use = hazard;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= BUBBLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (bus.mem_stall)            state_d = state;
    else if (bus.ex_branch_taken) state_d = FLUSH;
    else if (hazard)              state_d = BUBBLE;
    else                          state_d = RUN;
  end

  // A branch squashes the dependent instruction, so it outranks the load-use stall
  always_comb begin
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    bus.ifid_flush = 1'b0;
    ld_sel         = LD_FIELDS;
    cnt_inc        = 1'b0;
    if (bus.mem_stall) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      ld_sel         = LD_HOLD;
    end else if (bus.ex_branch_taken) begin
      bus.ifid_flush = 1'b1;
      ld_sel         = LD_BUBBLE;
    end else if (hazard) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      ld_sel         = LD_BUBBLE;
      cnt_inc        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || ld_sel == LD_BUBBLE) begin
      bus.idex_valid   <= 1'b0;
      bus.idex_rs      <= {REG_W{1'b0}};
      bus.idex_rt      <= {REG_W{1'b0}};
      bus.idex_rd      <= {REG_W{1'b0}};
      bus.idex_rs_data <= {DATA_W{1'b0}};
      bus.idex_rt_data <= {DATA_W{1'b0}};
      bus.idex_imm     <= {DATA_W{1'b0}};
      bus.idex_alu_op  <= 4'd0;
      {bus.idex_reg_write, bus.idex_mem_read, bus.idex_mem_write, bus.idex_mem_to_reg} <= CTRL_BUBBLE;
    end else if (ld_sel == LD_FIELDS) begin
      bus.idex_valid      <= bus.id_valid;
      bus.idex_rs         <= bus.id_rs;
      bus.idex_rt         <= bus.id_rt;
      bus.idex_rd         <= bus.id_rd;
      bus.idex_rs_data    <= bus.id_rs_data;
      bus.idex_rt_data    <= bus.id_rt_data;
      bus.idex_imm        <= bus.id_imm;
      bus.idex_alu_op     <= bus.id_alu_op;
      bus.idex_reg_write  <= bus.id_reg_write;
      bus.idex_mem_read   <= bus.id_mem_read;
      bus.idex_mem_write  <= bus.id_mem_write;
      bus.idex_mem_to_reg <= bus.id_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                               bus.stall_count <= {CNT_W{1'b0}};
    else if (cnt_inc && bus.stall_count != CNT_MAX) bus.stall_count <= bus.stall_count + CNT_W'(1);
  end
endmodule
